// File: rtl/tjmono2_rx_pkg.sv
// Shared types and constants for the TJ-Monopix2 RX delay scan.
// Defaults match the RX core register-7 reset values.
package tjmono2_rx_pkg;

  localparam int N_TAPS  = 32;
  localparam int N_EDGES = 2;
  localparam int TAP_W   = 5;
  localparam int LEN_W   = 6;
  localparam int CNT_W   = 24;

  localparam logic [TAP_W-1:0] RX_DEFAULT_DLY  = 5'd2;
  localparam logic             RX_DEFAULT_EDGE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SNAP,
    DWELL,
    EVAL,
    FINAL,
    DONE_ST
  } state_t;

  // Centre of a window; the sum stays within 0..31 for any real window.
  function automatic logic [TAP_W-1:0] centre_tap(
    input logic [TAP_W-1:0] start,
    input logic [LEN_W-1:0] len
  );
    logic [LEN_W-1:0] half;
    half = (len - 6'd1) >> 1;
    return TAP_W'({1'b0, start} + half);
  endfunction

endpackage

// File: rtl/tjmono2_rx_window_tracker.sv
// Tracks the current and the longest passing tap run of the sweep.
// Ties keep the earlier window because only a strictly longer run wins.
module tjmono2_rx_window_tracker
  import tjmono2_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  input  logic             edge_sel,
  output logic [LEN_W-1:0] best_len,
  output logic [TAP_W-1:0] centre,
  output logic             best_edge
);

  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] run_len;
  logic [TAP_W-1:0] cur_start;
  logic [TAP_W-1:0] run_start;
  logic [TAP_W-1:0] best_start;
  logic             last_tap;

  // Length and start the run would have if this point passes.
  always_comb begin
    run_len   = cur_len + 6'd1;
    run_start = (cur_len == '0) ? tap : cur_start;
    last_tap  = (tap == TAP_W'(N_TAPS - 1));
  end

  // Run registers; runs never wrap from tap 31 into the next edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_len    <= '0;
      cur_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
      best_edge  <= 1'b0;
    end else if (eval) begin
      if (pass) begin
        cur_start <= run_start;
        cur_len   <= last_tap ? '0 : run_len;
        if (run_len > best_len) begin
          best_len   <= run_len;
          best_start <= run_start;
          best_edge  <= edge_sel;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

  assign centre = centre_tap(best_start, best_len);

endmodule

// File: rtl/tjmono2_rx_dly_scan.sv
// Link-training sweep over 32 delay taps x 2 IDDR edges.
// Programs the centre of the longest passing window when done.
module tjmono2_rx_dly_scan
  import tjmono2_rx_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 16,
  parameter int               DWELL_CYCLES  = 65536,
  parameter int               MIN_WINDOW    = 4,
  parameter logic [TAP_W-1:0] DEFAULT_DLY   = RX_DEFAULT_DLY,
  parameter logic             DEFAULT_EDGE  = RX_DEFAULT_EDGE
)(
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic                        START,
  input  logic                        RX_READY,
  input  logic [7:0]                  DEC_ERR_CNT,
  output logic [TAP_W-1:0]            DLY_VALUE,
  output logic                        DLY_LOAD,
  output logic                        SAMPLING_EDGE,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        FAIL,
  output logic [LEN_W-1:0]            BEST_LEN,
  output logic [N_TAPS*N_EDGES-1:0]   PASS_MAP
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap;
  logic             pt_edge;
  logic             ok;
  logic [7:0]       err_start;

  logic             settle_end;
  logic             dwell_end;
  logic             last_tap;
  logic             last_point;
  logic             pass;
  logic             clear;
  logic             eval;
  logic             win_ok;

  logic [LEN_W-1:0] best_len;
  logic [TAP_W-1:0] centre;
  logic             best_edge;

  assign settle_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign dwell_end  = (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign last_tap   = (tap == TAP_W'(N_TAPS - 1));
  assign last_point = last_tap & pt_edge;
  assign pass       = ok & (DEC_ERR_CNT == err_start)
                    & (DEC_ERR_CNT != 8'hFF);
  assign clear      = (state == IDLE) & START;
  assign eval       = (state == EVAL);
  assign win_ok     = (best_len >= LEN_W'(MIN_WINDOW));
  assign BUSY       = (state != IDLE) && (state != DONE_ST);

  tjmono2_rx_window_tracker u_track (
    .clk       (BUS_CLK),
    .rst       (BUS_RST),
    .clear     (clear),
    .eval      (eval),
    .pass      (pass),
    .tap       (tap),
    .edge_sel  (pt_edge),
    .best_len  (best_len),
    .centre    (centre),
    .best_edge (best_edge)
  );

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; START is only honoured in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (START) state_nx = APPLY;
      APPLY:   state_nx = SETTLE;
      SETTLE:  if (settle_end) state_nx = SNAP;
      SNAP:    state_nx = DWELL;
      DWELL:   if (dwell_end) state_nx = EVAL;
      EVAL:    state_nx = last_point ? FINAL : APPLY;
      FINAL:   state_nx = DONE_ST;
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sweep datapath, delay-line programming and sticky results.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      DLY_VALUE     <= DEFAULT_DLY;
      SAMPLING_EDGE <= DEFAULT_EDGE;
      DLY_LOAD      <= 1'b0;
      DONE          <= 1'b0;
      FAIL          <= 1'b0;
      BEST_LEN      <= '0;
      PASS_MAP      <= '0;
      cnt           <= '0;
      tap           <= '0;
      pt_edge       <= 1'b0;
      ok            <= 1'b0;
      err_start     <= '0;
    end else begin
      DLY_LOAD <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            DONE     <= 1'b0;
            FAIL     <= 1'b0;
            BEST_LEN <= '0;
            PASS_MAP <= '0;
            tap      <= '0;
            pt_edge  <= 1'b0;
          end
        end
        APPLY: begin
          DLY_VALUE     <= tap;
          SAMPLING_EDGE <= pt_edge;
          DLY_LOAD      <= 1'b1;
          cnt           <= '0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        SNAP: begin
          err_start <= DEC_ERR_CNT;
          ok        <= 1'b1;
          cnt       <= '0;
        end
        DWELL: begin
          cnt <= cnt + 1'b1;
          if (!RX_READY) ok <= 1'b0;
        end
        EVAL: begin
          PASS_MAP[{pt_edge, tap}] <= pass;
          tap <= tap + 1'b1;
          if (last_tap) pt_edge <= 1'b1;
        end
        FINAL: begin
          if (win_ok) begin
            DLY_VALUE     <= centre;
            SAMPLING_EDGE <= best_edge;
            FAIL          <= 1'b0;
          end else begin
            DLY_VALUE     <= DEFAULT_DLY;
            SAMPLING_EDGE <= DEFAULT_EDGE;
            FAIL          <= 1'b1;
          end
          DLY_LOAD <= 1'b1;
          BEST_LEN <= best_len;
        end
        DONE_ST: DONE <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tjmono2_rx_dly_scan.sv
// Directed bench for the RX delay scan with a small link emulator.
// Short settle/dwell keep one sweep at 64*39+2 cycles.
module tb_tjmono2_rx_dly_scan;

  localparam int SETTLE = 4;
  localparam int DWELL  = 32;
  localparam int SCAN   = 64 * (SETTLE + DWELL + 3) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  err_cnt = 8'd0;
  logic [4:0]  dly_value;
  logic        dly_load;
  logic        samp_edge;
  logic        busy;
  logic        done;
  logic        fail_flag;
  logic [5:0]  best_len;
  logic [63:0] pass_map;

  logic [63:0] pat = '1;
  logic        force_sat = 1'b0;
  logic        glitch_en = 1'b0;
  int          tick = 0;
  int          gcnt = 0;

  int vec = 0;
  int err = 0;

  tjmono2_rx_dly_scan #(
    .SETTLE_CYCLES (SETTLE),
    .DWELL_CYCLES  (DWELL),
    .MIN_WINDOW    (4)
  ) dut (
    .BUS_CLK       (clk),
    .BUS_RST       (rst),
    .START         (start),
    .RX_READY      (rx_ready),
    .DEC_ERR_CNT   (err_cnt),
    .DLY_VALUE     (dly_value),
    .DLY_LOAD      (dly_load),
    .SAMPLING_EDGE (samp_edge),
    .BUSY          (busy),
    .DONE          (done),
    .FAIL          (fail_flag),
    .BEST_LEN      (best_len),
    .PASS_MAP      (pass_map)
  );

  always #5 clk = ~clk;

  // Link emulator: bad settings accumulate decoder errors every 16 cycles.
  always @(negedge clk) begin
    tick = (tick + 1) % 16;
    if (force_sat)
      err_cnt = 8'hFF;
    else if (!pat[{samp_edge, dly_value}] && tick == 0 && err_cnt != 8'hFF)
      err_cnt = err_cnt + 8'd1;
    if (dly_load && dly_value == 5'd7 && !samp_edge) gcnt = 1;
    else if (gcnt != 0) gcnt = gcnt + 1;
    rx_ready = !(glitch_en && gcnt == 20);
  end

  task automatic run_scan(input logic [63:0] p, input int restart_at,
                          output int cycles, output int busy_n,
                          output int last_load);
    pat = p;
    if (!force_sat) err_cnt = 8'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0; busy_n = 0; last_load = -1;
    while (!done && cycles < 5000) begin
      if (busy) busy_n++;
      if (dly_load) last_load = cycles;
      start = (cycles == restart_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    vec++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL scan_timeout: done=%b after %0d cycles, required 1", done, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (dly_value !== 5'd2) begin err++; $display("FAIL rst_dly: got %0d want 2", dly_value); end
    vec++; if (samp_edge !== 1'b1) begin err++; $display("FAIL rst_edge: got %b want 1", samp_edge); end
    vec++; if ({dly_load, busy, done, fail_flag} !== 4'b0) begin
      err++; $display("FAIL rst_flags: load/busy/done/fail=%b want 0000", {dly_load, busy, done, fail_flag}); end
    vec++; if (best_len !== 6'd0 || pass_map !== 64'd0) begin
      err++; $display("FAIL rst_result: best=%0d map=%h want 0/0", best_len, pass_map); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    int c, b, l;
    run_scan('1, -1, c, b, l);
    vec++; if (c != SCAN) begin err++; $display("FAIL allpass_cycles: got %0d want %0d", c, SCAN); end
    vec++; if (b != SCAN - 1) begin err++; $display("FAIL allpass_busy: got %0d want %0d", b, SCAN - 1); end
    vec++; if (l != SCAN - 1) begin err++; $display("FAIL allpass_lastload: got %0d want %0d", l, SCAN - 1); end
    vec++; if (best_len !== 6'd32) begin err++; $display("FAIL allpass_best: got %0d want 32", best_len); end
    vec++; if (dly_value !== 5'd15 || samp_edge !== 1'b0) begin
      err++; $display("FAIL allpass_cfg: got %0d/%b want 15/0", dly_value, samp_edge); end
    vec++; if (fail_flag !== 1'b0) begin err++; $display("FAIL allpass_failflag: got %b want 0", fail_flag); end
    vec++; if (pass_map !== '1) begin err++; $display("FAIL allpass_map: got %h want all ones", pass_map); end
    repeat (5) @(negedge clk);
    vec++; if (done !== 1'b1 || busy !== 1'b0 || best_len !== 6'd32) begin
      err++; $display("FAIL allpass_hold: done/busy/best=%b/%b/%0d want 1/0/32", done, busy, best_len); end
  endtask

  task automatic test_window_select();
    int c, b, l;
    logic [63:0] p;
    p = 64'hFFF0_0000_0000_03F8;
    run_scan(p, -1, c, b, l);
    vec++; if (best_len !== 6'd12) begin err++; $display("FAIL win_best: got %0d want 12", best_len); end
    vec++; if (dly_value !== 5'd25 || samp_edge !== 1'b1) begin
      err++; $display("FAIL win_cfg: got %0d/%b want 25/1", dly_value, samp_edge); end
    vec++; if (pass_map !== p) begin err++; $display("FAIL win_map: got %h want %h", pass_map, p); end
    vec++; if (fail_flag !== 1'b0) begin err++; $display("FAIL win_failflag: got %b want 0", fail_flag); end
  endtask

  task automatic test_tie();
    int c, b, l;
    run_scan(64'h0000_001F_0000_7C00, -1, c, b, l);
    vec++; if (best_len !== 6'd5) begin err++; $display("FAIL tie_best: got %0d want 5", best_len); end
    vec++; if (dly_value !== 5'd12 || samp_edge !== 1'b0) begin
      err++; $display("FAIL tie_cfg: got %0d/%b want 12/0", dly_value, samp_edge); end
  endtask

  task automatic test_min_window();
    int c, b, l;
    run_scan(64'h0000_0000_0000_01C0, -1, c, b, l);
    vec++; if (best_len !== 6'd3) begin err++; $display("FAIL minwin_best: got %0d want 3", best_len); end
    vec++; if (fail_flag !== 1'b1 || done !== 1'b1) begin
      err++; $display("FAIL minwin_flags: fail/done=%b/%b want 1/1", fail_flag, done); end
    vec++; if (dly_value !== 5'd2 || samp_edge !== 1'b1) begin
      err++; $display("FAIL minwin_cfg: got %0d/%b want 2/1", dly_value, samp_edge); end
    vec++; if (l != SCAN - 1) begin err++; $display("FAIL minwin_load: last load at %0d want %0d", l, SCAN - 1); end
    vec++; if (pass_map !== 64'h1C0) begin err++; $display("FAIL minwin_map: got %h want 1c0", pass_map); end
  endtask

  task automatic test_all_fail();
    int c, b, l;
    run_scan(64'd0, -1, c, b, l);
    vec++; if (best_len !== 6'd0 || fail_flag !== 1'b1) begin
      err++; $display("FAIL allfail_res: best/fail=%0d/%b want 0/1", best_len, fail_flag); end
    vec++; if (pass_map !== 64'd0) begin err++; $display("FAIL allfail_map: got %h want 0", pass_map); end
  endtask

  task automatic test_rx_glitch();
    int c, b, l;
    logic [63:0] e;
    e = '1;
    e[7] = 1'b0;
    glitch_en = 1'b1;
    run_scan('1, -1, c, b, l);
    glitch_en = 1'b0;
    vec++; if (pass_map !== e) begin err++; $display("FAIL glitch_map: got %h want %h", pass_map, e); end
    vec++; if (best_len !== 6'd32 || dly_value !== 5'd15 || samp_edge !== 1'b1) begin
      err++; $display("FAIL glitch_cfg: best/dly/edge=%0d/%0d/%b want 32/15/1", best_len, dly_value, samp_edge); end
  endtask

  task automatic test_err_saturated();
    int c, b, l;
    force_sat = 1'b1;
    err_cnt = 8'hFF;
    run_scan('1, -1, c, b, l);
    force_sat = 1'b0;
    vec++; if (pass_map !== 64'd0) begin err++; $display("FAIL sat_map: got %h want 0", pass_map); end
    vec++; if (best_len !== 6'd0 || fail_flag !== 1'b1) begin
      err++; $display("FAIL sat_res: best/fail=%0d/%b want 0/1", best_len, fail_flag); end
  endtask

  task automatic test_reset_mid_scan();
    pat = '1;
    err_cnt = 8'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    vec++; if (busy !== 1'b1 || dly_value !== 5'd0 || samp_edge !== 1'b0) begin
      err++; $display("FAIL midrst_pre: busy/dly/edge=%b/%0d/%b want 1/0/0", busy, dly_value, samp_edge); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (busy !== 1'b0 || done !== 1'b0 || dly_load !== 1'b0) begin
      err++; $display("FAIL midrst_flags: busy/done/load=%b/%b/%b want 0/0/0", busy, done, dly_load); end
    vec++; if (dly_value !== 5'd2 || samp_edge !== 1'b1) begin
      err++; $display("FAIL midrst_cfg: got %0d/%b want 2/1", dly_value, samp_edge); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vec++; if (busy !== 1'b0 || dly_load !== 1'b0) begin
      err++; $display("FAIL midrst_idle: busy/load=%b/%b want 0/0", busy, dly_load); end
  endtask

  task automatic test_back_to_back();
    int c, b, l;
    run_scan('1, 100, c, b, l);
    vec++; if (c != SCAN) begin err++; $display("FAIL restart_cycles: got %0d want %0d", c, SCAN); end
    vec++; if (best_len !== 6'd32 || dly_value !== 5'd15) begin
      err++; $display("FAIL restart_res: best/dly=%0d/%0d want 32/15", best_len, dly_value); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_window_select();
    test_tie();
    test_min_window();
    test_all_fail();
    test_rx_glitch();
    test_err_saturated();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
